// File: rtl/exc_ctrl.sv
// Exception/return sequencer: prioritises MEM-stage traps, eret and the pending
// interrupt, strobes CP0, flushes the pipeline, then redirects fetch.
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter logic [4:0]  CAUSE_SYSCALL = 5'd8,
    parameter logic [4:0]  CAUSE_BREAK   = 5'd9,
    parameter logic [4:0]  CAUSE_TEQ     = 5'd13,
    parameter logic [4:0]  CAUSE_INT     = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req_syscall,
    input  logic        req_break,
    input  logic        req_teq,
    input  logic        req_eret,
    input  logic [31:0] req_pc,
    input  logic        irq,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    // state    | meaning
    // IDLE     | waiting for a request (only state that accepts one)
    // ENTER    | exception strobe to CP0, flush begins
    // RET      | eret strobe to CP0, flush begins
    // FLUSH    | flush held for FLUSH_CYCLES cycles
    // REDIRECT | one-cycle fetch PC override, last flush cycle
    typedef enum logic [2:0] {IDLE, ENTER, RET, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       pend_irq;

    logic take_brk, take_sys, take_teq, take_int;
    logic unused_status;

    assign take_brk = req_break   & status[0] & status[2];
    assign take_sys = req_syscall & status[0] & status[1];
    assign take_teq = req_teq     & status[0] & status[3];
    assign take_int = pend_irq    & status[0] & status[4];
    assign unused_status = ^status[31:5];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            pend_irq      <= 1'b0;
            cp0_exception <= 1'b0;
            cp0_eret      <= 1'b0;
            cp0_cause     <= 5'd0;
            cp0_pc        <= 32'd0;
            flush         <= 1'b0;
            redirect      <= 1'b0;
            redirect_pc   <= 32'd0;
            busy          <= 1'b0;
        end else begin
            cp0_exception <= 1'b0;
            cp0_eret      <= 1'b0;
            redirect      <= 1'b0;
            if (irq)
                pend_irq <= 1'b1;
            case (state)
                IDLE: begin
                    if (!stall) begin
                        if (take_brk || take_sys || take_teq) begin
                            state         <= ENTER;
                            cp0_exception <= 1'b1;
                            flush         <= 1'b1;
                            busy          <= 1'b1;
                            cp0_pc        <= req_pc;
                            if (take_brk)
                                cp0_cause <= CAUSE_BREAK;
                            else if (take_sys)
                                cp0_cause <= CAUSE_SYSCALL;
                            else
                                cp0_cause <= CAUSE_TEQ;
                        end else if (req_eret) begin
                            state    <= RET;
                            cp0_eret <= 1'b1;
                            flush    <= 1'b1;
                            busy     <= 1'b1;
                        end else if (take_int) begin
                            // taking the interrupt wins over a same-cycle irq re-assertion
                            state         <= ENTER;
                            cp0_exception <= 1'b1;
                            flush         <= 1'b1;
                            busy          <= 1'b1;
                            cp0_pc        <= req_pc;
                            cp0_cause     <= CAUSE_INT;
                            pend_irq      <= 1'b0;
                        end
                    end
                end
                ENTER, RET: begin
                    redirect_pc <= exc_addr;
                    cnt         <= FLUSH_LOAD;
                    state       <= FLUSH;
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state    <= REDIRECT;
                        redirect <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    state <= IDLE;
                    flush <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic, every cycle
// compared against a phase-counting transaction model.
module tb_exc_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst, stall, req_syscall, req_break, req_teq, req_eret, irq;
    logic [31:0] req_pc, status, exc_addr;
    logic        cp0_exception, cp0_eret, flush, redirect, busy;
    logic [4:0]  cp0_cause;
    logic [31:0] cp0_pc, redirect_pc;

    int n_chk = 0;
    int n_err = 0;

    // model: phase -1 = idle, 0 = strobe cycle, 1..FC = flush, FC+1 = redirect
    int          m_phase = -1;
    bit          m_is_eret;
    bit          m_pend;
    logic [4:0]  m_cause;
    logic [31:0] m_pc, m_rpc;

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_syscall(req_syscall), .req_break(req_break), .req_teq(req_teq),
        .req_eret(req_eret), .req_pc(req_pc), .irq(irq), .status(status),
        .exc_addr(exc_addr), .cp0_exception(cp0_exception), .cp0_eret(cp0_eret),
        .cp0_cause(cp0_cause), .cp0_pc(cp0_pc), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit taken = 0;
        if (rst) begin
            m_phase = -1; m_pend = 0; m_cause = 5'd0; m_pc = 32'd0; m_rpc = 32'd0;
            m_is_eret = 0;
            return;
        end
        if (m_phase == -1) begin
            if (!stall) begin
                if (status[0] && req_break && status[2]) begin
                    m_phase = 0; m_is_eret = 0; m_cause = 5'd9; m_pc = req_pc;
                end else if (status[0] && req_syscall && status[1]) begin
                    m_phase = 0; m_is_eret = 0; m_cause = 5'd8; m_pc = req_pc;
                end else if (status[0] && req_teq && status[3]) begin
                    m_phase = 0; m_is_eret = 0; m_cause = 5'd13; m_pc = req_pc;
                end else if (req_eret) begin
                    m_phase = 0; m_is_eret = 1;
                end else if (status[0] && m_pend && status[4]) begin
                    m_phase = 0; m_is_eret = 0; m_cause = 5'd0; m_pc = req_pc; taken = 1;
                end
            end
        end else if (m_phase == 0) begin
            m_rpc = exc_addr;
            m_phase = 1;
        end else if (m_phase <= FC) begin
            m_phase++;
        end else begin
            m_phase = -1;
        end
        if (taken) m_pend = 0;
        else if (irq) m_pend = 1;
    endtask

    task automatic cyc(input logic r, input logic st, input logic sc, input logic bk,
                       input logic tq, input logic er, input logic iq,
                       input logic [31:0] stat, input logic [31:0] pc, input logic [31:0] ea);
        rst = r; stall = st; req_syscall = sc; req_break = bk; req_teq = tq;
        req_eret = er; irq = iq; status = stat; req_pc = pc; exc_addr = ea;
        @(posedge clk);
        model_edge();
        #1;
        check("cp0_exception", 32'(cp0_exception), 32'(m_phase == 0 && !m_is_eret));
        check("cp0_eret",      32'(cp0_eret),      32'(m_phase == 0 && m_is_eret));
        check("flush",         32'(flush),         32'(m_phase >= 0));
        check("redirect",      32'(redirect),      32'(m_phase == FC + 1));
        check("busy",          32'(busy),          32'(m_phase >= 0));
        check("cp0_cause",     32'(cp0_cause),     32'(m_cause));
        check("cp0_pc",        cp0_pc,             m_pc);
        check("redirect_pc",   redirect_pc,        m_rpc);
    endtask

    task automatic idle_n(input int n, input logic [31:0] stat, input logic [31:0] ea);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, stat, 32'h0, ea);
    endtask

    int pulses;

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        idle_n(2, 32'h1F, 32'h0);

        // syscall: flush 4 cycles, redirect in the 4th
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h1F, 32'h0040_0020, 32'h0040_0004);
        check("sys_cause", 32'(cp0_cause), 32'd8);
        idle_n(4, 32'h1F, 32'h0040_0004);
        check("sys_done_busy", 32'(busy), 32'd0);

        // priority: break > syscall > teq, then break masked
        cyc(0, 0, 1, 1, 1, 0, 0, 32'h1F, 32'h0000_1000, 32'h0000_0080);
        check("prio_brk", 32'(cp0_cause), 32'd9);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1, 1, 0, 0, 32'h1F, 32'h0000_1004, 32'h0000_0080);
            pulses += int'(cp0_exception);
        end
        check("prio_single_pulse", 32'(pulses), 32'd0);
        cyc(0, 0, 1, 1, 1, 0, 0, 32'h1B, 32'h0000_2000, 32'h0000_0080);
        check("prio_sys", 32'(cp0_cause), 32'd8);
        idle_n(4, 32'h1B, 32'h0000_0080);

        // masking: global disable drops teq; irq pends until enabled
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h1E, 32'h0000_3000, 32'h0);
        idle_n(2, 32'h1E, 32'h0);
        check("mask_busy", 32'(busy), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0F, 32'h0000_4000, 32'h0);
        idle_n(3, 32'h0F, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h1F, 32'h0000_4444, 32'h0000_0180);
        check("irq_cause", 32'(cp0_cause), 32'd0);
        idle_n(5, 32'h1F, 32'h0000_0180);

        // eret, then eret collides with syscall
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h1F, 32'h0, 32'h0040_0120);
        idle_n(4, 32'h1F, 32'h0040_0120);
        check("eret_target", redirect_pc, 32'h0040_0120);
        cyc(0, 0, 1, 0, 0, 1, 0, 32'h1F, 32'h0000_5000, 32'h0000_0080);
        check("eret_lost", 32'(cp0_eret), 32'd0);
        idle_n(4, 32'h1F, 32'h0000_0080);

        // stall holds off a request; mid-flush request ignored; 1-cycle irq served later
        cyc(0, 1, 0, 1, 0, 0, 0, 32'h1F, 32'h0000_6000, 32'h0000_0080);
        cyc(0, 1, 0, 1, 0, 0, 0, 32'h1F, 32'h0000_6000, 32'h0000_0080);
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h1F, 32'h0000_6000, 32'h0000_0080);
        cyc(0, 0, 1, 0, 0, 0, 0, 32'h1F, 32'h0000_7000, 32'h0000_0090);
        cyc(0, 0, 1, 0, 0, 0, 1, 32'h1F, 32'h0000_7000, 32'h0000_0090);
        idle_n(6, 32'h1F, 32'h0000_0090);

        // reset mid-flush clears pend_irq
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h1F, 32'h0000_8000, 32'h0000_0080);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h1F, 32'h0, 32'h0000_0080);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h1F, 32'h0, 32'h0000_0080);
        check("rst_flush", 32'(flush), 32'd0);
        idle_n(4, 32'h1F, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] st;
            case ($urandom_range(0, 4))
                0: st = 32'h1F;
                1: st = 32'h1E;
                2: st = 32'h1B;
                3: st = 32'h0F;
                default: st = $urandom;
            endcase
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 11) == 0, st, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/return sequencer for the static pipeline. It collects trap requests from the MEM stage and the external interrupt line, and prioritises them against the CP0 status mask. It drives the CP0 exception/eret strobes, cause code and faulting PC, flushes the pipeline for a fixed number of cycles, then redirects the fetch PC to the handler or EPC target. It sits between the MEM-stage decode and the CP0 register file.

## Interface

Parameters:
- FLUSH_CYCLES, 2: cycles `flush` is held after the ENTER/RET cycle; legal range 1..15.
- CAUSE_SYSCALL, 5'd8; CAUSE_BREAK, 5'd9; CAUSE_TEQ, 5'd13; CAUSE_INT, 5'd0: cause codes sent to CP0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; no new request is accepted while it is high.
- req_syscall, req_break, req_teq  in  1 each  MEM-stage trap requests (teq = trap condition already true).
- req_eret  in  1  MEM-stage eret instruction.
- req_pc  in  32  PC of the MEM-stage instruction.
- irq  in  1  external interrupt, level.
- status  in  32  CP0 status. Bit 0 is global enable; bits 1/2/3/4 enable syscall/break/teq/irq.
- exc_addr  in  32  CP0 handler/EPC address (EPC while `cp0_eret`=1, otherwise the vector).
- cp0_exception  out  1  exception strobe to CP0.
- cp0_eret  out  1  eret strobe to CP0.
- cp0_cause  out  5  cause code.
- cp0_pc  out  32  PC written to EPC.
- flush  out  1  squash IF..MEM stage registers.
- redirect  out  1  one-cycle PC override.
- redirect_pc  out  32  target while `redirect`=1.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, ENTER, RET, FLUSH, REDIRECT. Reset puts the block in IDLE, clears the flush counter, `pend_irq`, `cp0_cause`, `cp0_pc` and `redirect_pc`, and drives every output to 0.
- A trap is enabled when `status[0]` is set and its own enable bit is set. A disabled trap is dropped with no action and is never remembered.
- `pend_irq` is set on any cycle with `irq`=1, in any state. It is cleared only when the interrupt is taken.
- Request acceptance, IDLE with `stall`=0. The first matching rule wins:
  1. enabled break
  2. enabled syscall
  3. enabled teq
  4. `req_eret`
  5. `pend_irq` enabled
- A trap or interrupt goes IDLE->ENTER. `cp0_cause` takes the matching code and `cp0_pc` takes `req_pc`. For an interrupt, `cp0_pc` takes `req_pc` (the interrupted instruction).
- eret goes IDLE->RET. If a trap and `req_eret` arrive together, the trap wins and the eret is discarded.
- ENTER: `cp0_exception`=1 and `flush`=1. `redirect_pc` loads `exc_addr` at the closing edge. Next state is FLUSH.
- RET: `cp0_eret`=1 and `flush`=1. `redirect_pc` loads `exc_addr` (EPC) at the closing edge. Next state is FLUSH.
- FLUSH: `flush`=1 for exactly FLUSH_CYCLES cycles, counted by a 4-bit down-counter. Then REDIRECT.
- REDIRECT: `redirect`=1 and `flush`=1 for one cycle, then IDLE.
- `stall` is ignored outside IDLE; an active sequence always completes.
- Requests in states other than IDLE are ignored. `irq` is the exception: it still sets `pend_irq`.
- `rst` in any state returns to IDLE on the next edge with all outputs 0 and `pend_irq` cleared.

## Timing

- Request sampled at edge T (IDLE, `stall`=0) → ENTER/RET during T..T+1.
- FLUSH occupies cycles T+1 .. T+FLUSH_CYCLES.
- REDIRECT is cycle T+FLUSH_CYCLES+1.
- IDLE resumes at T+FLUSH_CYCLES+2. Total latency is FLUSH_CYCLES+2 cycles with `busy`=1 throughout.
- `cp0_exception` and `cp0_eret` are single-cycle, mutually exclusive, registered pulses. `cp0_cause` and `cp0_pc` are stable from ENTER through the end of REDIRECT.
- `flush` is continuously high from ENTER/RET through REDIRECT inclusive.
- A new request is accepted no earlier than the first IDLE cycle; back-to-back sequences are possible.

## Test plan

- **Syscall:** `status`=0x1F, `req_syscall`=1, `req_pc`=0x00400020, FLUSH_CYCLES=2 → ENTER with `cp0_cause`=8 and `cp0_pc`=0x00400020; `flush` high for 4 cycles; `redirect`=1 with `redirect_pc`=0x00400004 in the 4th cycle; `busy` falls after it.
- **Priority:** `req_break`, `req_syscall` and `req_teq` together, `status`=0x1F → `cp0_cause`=9 and a single `cp0_exception` pulse. Repeat with `status`=0x1B → `cp0_cause`=8.
- **Masking:** `status`=0x1E with `req_teq`=1 → no strobe and `busy` stays 0. `status`=0x0F with `irq` pulsed, then `status`=0x1F → interrupt taken with `cp0_cause`=0.
- **Eret:** `exc_addr`=0x00400120 while `cp0_eret`=1 → RET, one `cp0_eret` pulse, `redirect_pc`=0x00400120. Simultaneous `req_eret` and enabled `req_syscall` → ENTER only.
- **Busy window:** `stall`=1 in IDLE with a request → no action until `stall` drops. A request raised mid-FLUSH is ignored, and a 1-cycle `irq` is served after return to IDLE.
- **Reset mid-sequence:** `rst`=1 during FLUSH → next cycle IDLE with `flush`/`redirect`/`busy`=0 and `pend_irq` cleared.
